// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding, limits and helpers for the clock divider.
package clk_div_pkg;
    typedef enum logic [1:0] {STOPPED, RUN, DRAIN} state_t;
    localparam int DIV_MIN = 2;
    function automatic logic [31:0] half_ceil(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter with registered tick and divided waveform.
module clk_div_core import clk_div_pkg::*; #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_load_ok,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tick,
    output logic             o_div_out
);
    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             r_div_out;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W:0]   w_half;
    // outputs are computed from next-cycle count/divisor so they align with the held count
    assign w_cnt_nxt = (!i_run || i_load_ok) ? '0 : r_count + CNT_W'(1);
    assign w_half    = (CNT_W+1)'(half_ceil(32'(i_div)));
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_tick    <= 1'b0;
            r_div_out <= 1'b0;
        end else begin
            r_count   <= w_cnt_nxt;
            r_tick    <= i_run && (w_cnt_nxt == i_div - CNT_W'(1));
            r_div_out <= i_run && ({1'b0, w_cnt_nxt} < w_half);
        end
    end
    assign o_count   = r_count;
    assign o_tick    = r_tick;
    assign o_div_out = r_div_out;
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with clean start/stop and
// boundary-synchronous divisor updates over a valid/ready handshake.
module clk_div_ctrl import clk_div_pkg::*; #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             tick,
    output logic             div_out,
    output logic             busy
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend_valid;
    logic             r_cfg_err;
    logic             r_busy;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_div_nxt;
    logic             w_running;
    logic             w_bound;
    logic             w_xfer;
    logic             w_legal;
    logic             w_load;
    assign w_running   = r_state != STOPPED;
    assign w_bound     = w_running && (w_count == r_cur_div - CNT_W'(1));
    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_legal     = cfg_div >= CNT_W'(DIV_MIN);
    assign w_load      = w_xfer && w_legal;
    assign w_state_nxt = enable ? RUN : (w_running && !w_bound) ? DRAIN : STOPPED;
    // a transfer while stopped or on the boundary bypasses the pending slot
    assign w_div_nxt   = (w_load && (!w_running || w_bound)) ? cfg_div :
                         (w_bound && r_pend_valid) ? r_pend_div : r_cur_div;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= STOPPED;
            r_cur_div    <= CNT_W'(DEFAULT_DIV);
            r_pend_div   <= '0;
            r_pend_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_div    <= w_div_nxt;
            r_pend_valid <= (w_load && w_running && !w_bound) ? 1'b1 : w_bound ? 1'b0 : r_pend_valid;
            r_pend_div   <= (w_load && w_running && !w_bound) ? cfg_div : r_pend_div;
            r_cfg_err    <= w_xfer && !w_legal;
            r_busy       <= w_state_nxt != STOPPED;
        end
    end
    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk       (clk),
        .reset     (reset),
        .i_run     (w_state_nxt != STOPPED),
        .i_div     (w_div_nxt),
        .i_load_ok (!w_running || w_bound),
        .o_count   (w_count),
        .o_tick    (tick),
        .o_div_out (div_out)
    );
    assign cfg_ready = !r_pend_valid;
    assign cfg_err   = r_cfg_err;
    assign cur_div   = r_cur_div;
    assign busy      = r_busy;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed scoreboard bench for the clock divider controller.
module tb_clk_div_ctrl;
    typedef struct packed {
        logic       tick;
        logic       div_out;
        logic       busy;
        logic       ready;
        logic       err;
        logic [7:0] cur;
    } obs_t;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic [7:0] cur_div;
    logic       tick;
    logic       div_out;
    logic       busy;
    obs_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    string      tag;
    always #5 clk = ~clk;
    clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_div   (cur_div),
        .tick      (tick),
        .div_out   (div_out),
        .busy      (busy)
    );
    // advance one cycle, then pop the expectation for it and compare
    task automatic go();
        obs_t got;
        obs_t e;
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        got = '{tick, div_out, busy, cfg_ready, cfg_err, cur_div};
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: got tick/div/busy/rdy/err/cur=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                   tag, got.tick, got.div_out, got.busy, got.ready, got.err, got.cur,
                   e.tick, e.div_out, e.busy, e.ready, e.err, e.cur);
        end
    endtask
    task automatic idle(input int c);
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(c)});
        go();
    endtask
    task automatic one(input int n, input int k, input bit rdy, input bit err);
        exp_q.push_back('{k == n - 1, k < (n + 1) / 2, 1'b1, rdy, err, 8'(n)});
        go();
    endtask
    task automatic rn(input int n, input int k0, input int m, input bit rdy);
        for (int i = 0; i < m; i++) one(n, (k0 + i) % n, rdy, 1'b0);
    endtask
    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        tag = "reset";
        idle(3);
        idle(3);
        reset = 1'b0; enable = 1'b1;
        tag = "default_n3";
        rn(3, 0, 9, 1'b1);
        enable = 1'b0;
        tag = "stop_n3";
        idle(3);
        cfg_valid = 1'b1; cfg_div = 8'd4;
        tag = "cfg_stopped";
        idle(4);
        cfg_valid = 1'b0; enable = 1'b1;
        tag = "run_n4";
        rn(4, 0, 8, 1'b1);
        cfg_valid = 1'b1; cfg_div = 8'd5;
        tag = "boundary_xfer";
        rn(5, 0, 1, 1'b1);
        cfg_valid = 1'b0;
        rn(5, 1, 1, 1'b1);
        cfg_valid = 1'b1; cfg_div = 8'd2;
        tag = "pending";
        rn(5, 2, 1, 1'b0);
        cfg_valid = 1'b0;
        rn(5, 3, 2, 1'b0);
        tag = "run_n2";
        rn(2, 0, 6, 1'b1);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        tag = "illegal0";
        one(2, 0, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        one(2, 1, 1'b1, 1'b0);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        tag = "illegal1";
        one(2, 0, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        one(2, 1, 1'b1, 1'b0);
        cfg_valid = 1'b1; cfg_div = 8'd6;
        tag = "run_n6";
        rn(6, 0, 1, 1'b1);
        cfg_valid = 1'b0;
        rn(6, 1, 2, 1'b1);
        enable = 1'b0;
        tag = "drain";
        rn(6, 3, 3, 1'b1);
        idle(6);
        idle(6);
        enable = 1'b1;
        tag = "reenable";
        rn(6, 0, 3, 1'b1);
        enable = 1'b0;
        rn(6, 3, 2, 1'b1);
        enable = 1'b1;
        rn(6, 5, 1, 1'b1);
        rn(6, 0, 6, 1'b1);
        cfg_valid = 1'b1; cfg_div = 8'd255;
        tag = "n255";
        rn(255, 0, 1, 1'b1);
        cfg_valid = 1'b0;
        rn(255, 1, 254, 1'b1);
        rn(255, 0, 4, 1'b1);
        reset = 1'b1;
        tag = "mid_reset";
        idle(3);
        reset = 1'b0; enable = 1'b0;
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller. Divides clk by a run-time divisor N and produces a one-cycle tick per period plus a near-50% duty divided waveform.
- Sequences start/stop so every period completes cleanly.
- Accepts divisor updates over a valid/ready handshake and applies them only at period boundaries, so no runt or stretched period is ever produced.
- Used by downstream logic as the clock-enable source for all divided-rate domains. Single clock domain, no negedge logic.

Parameters:
- CNT_W, 8, width of divisor and period counter; legal N is 2 .. 2^CNT_W-1.
- DEFAULT_DIV, 3, divisor loaded at reset; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run divider, 0 = stop after the current period.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  CNT_W  offered divisor N.
- cfg_ready  out  1  controller can accept a divisor this cycle.
- cfg_err  out  1  one-cycle pulse; the accepted divisor was illegal (< 2) and was discarded.
- cur_div  out  CNT_W  divisor currently in effect.
- tick  out  1  one-cycle pulse on the last cycle of each period.
- div_out  out  1  divided waveform.
- busy  out  1  state != STOPPED.

Behaviour:
- Reset, all values registered:
  - state = STOPPED, count = 0, cur_div = DEFAULT_DIV.
  - Pending slot empty, cfg_ready = 1.
  - tick = 0, div_out = 0, cfg_err = 0, busy = 0.
- Reset asserted mid-period aborts the period immediately. Any pending divisor is lost.
- State machine:
  - STOPPED: count held at 0, tick = 0, div_out = 0. enable = 1 -> RUN; the first period begins next cycle with count = 0.
  - RUN: count increments 0 .. cur_div-1, then wraps to 0. The wrap cycle is the boundary. enable = 0 -> DRAIN.
  - DRAIN: counting continues. At the boundary -> STOPPED, with count = 0 and div_out = 0 next cycle. If enable returns to 1 before the boundary -> RUN with no break in the waveform.
- Outputs:
  - tick = 1 exactly when count == cur_div-1, in RUN or DRAIN.
  - div_out = 1 when count < ceil(cur_div/2).
    - N = 3: high 2 cycles, low 1.
    - N = 4: high 2, low 2.
  - tick and div_out come from flops and line up with the count value held in the same cycle. Latency from enable rising to the first div_out = 1 is 1 cycle.
- Config handshake:
  - Transfer happens when cfg_valid && cfg_ready.
  - cfg_ready = 0 while a legal divisor is pending, and 1 otherwise.
  - Accepted cfg_div < 2: cfg_err pulses next cycle, nothing is stored, cur_div is unchanged.
  - In STOPPED, a legal divisor loads cur_div next cycle; nothing is left pending.
  - In RUN or DRAIN, a legal divisor is stored as pending and loaded into cur_div at the next boundary. The following period uses the new N.
  - A transfer in the boundary cycle itself bypasses the pending slot: it takes effect for the period starting the next cycle.
  - Enable falling while a divisor is pending: the divisor is still applied at the DRAIN boundary.
- Arithmetic:
  - Unsigned, CNT_W bits.
  - ceil(N/2) = (N+1)>>1, computed in CNT_W+1 bits to avoid overflow at N = 2^CNT_W-1.
  - count never exceeds cur_div-1.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum (STOPPED, RUN, DRAIN);
  - DIV_MIN = 2;
  - a function half_ceil(N).
- One natural sub-module, clk_div_core: the counter plus tick/div_out generation, with inputs run, div, and load_ok. The FSM and config handshake stay in the top module.

Test Plan:
- Default divisor: release reset, enable = 1 -> div_out pattern 1,1,0 repeating. tick on every 3rd cycle. busy = 1.
- Even divisor in STOPPED: cfg_div = 4 -> cur_div = 4 next cycle; after enable = 1, pattern is 1,1,0,0 and tick period is 4.
- Mid-period update: running at N = 5, cfg_div = 2 at count = 1 -> cfg_ready = 0 until the boundary. The remaining period finishes at 5 cycles, then 1,0 repeating.
- Illegal divisors: cfg_div = 0 and cfg_div = 1 -> one-cycle cfg_err pulse each. cur_div is unchanged and the waveform is undisturbed.
- Drain and re-enable: N = 6, enable dropped at count = 2 -> the period completes, div_out = 0, busy = 0 after count 5. Repeat with enable re-raised at count 4 -> continuous waveform, busy never drops.
- Boundary and reset corners:
  - Config transfer on the boundary cycle is applied to the very next period.
  - N = 255 gives div_out high for 128 cycles.
  - Reset at count = 3 -> all outputs 0 and cur_div = 3 the next cycle.
